// File: rtl/rr_grant_arbiter.sv
// Round-robin grant arbiter.
// Shares one downstream resource among NUM_REQ requesters. One registered
// one-hot grant is issued at a time; the owner keeps it until it signals
// done, drops its request, or the hold-time limit (MAX_HOLD) expires.
// A rotating priority pointer gives fairness: after a release the pointer
// moves to the slot just past the previous owner.
//
// Handshake: a requester asserts req[i] and keeps it high while it wants the
// resource. It owns the resource in every cycle where grant[i]=1. It ends
// ownership by pulsing done[i] or lowering req[i]. The grant drops on the
// following edge. There is always at least one grant-free cycle between two
// owners, which gives a break-before-make handover.
module rr_grant_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int MAX_HOLD = 8,
    parameter int ID_W     = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] done,
    output logic [NUM_REQ-1:0] grant,
    output logic               grant_valid,
    output logic [ID_W-1:0]    grant_id,
    output logic               timeout,
    output logic               dbg_state
);

    // Hold counter only needs to reach MAX_HOLD-1.
    localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam bit TIMEOUT_EN = (MAX_HOLD > 0);
    localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD > 0) ? CNT_W'(MAX_HOLD - 1) : '0;
    localparam logic [ID_W:0] NREQ_EXT = (ID_W + 1)'(NUM_REQ);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } state_t;

    // Registered state
    state_t               r_state;
    logic [NUM_REQ-1:0]   r_grant;
    logic [ID_W-1:0]      r_grant_id;
    logic [ID_W-1:0]      r_ptr;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_timeout;

    // Next-state values
    state_t               w_state_nxt;
    logic [NUM_REQ-1:0]   w_grant_nxt;
    logic [ID_W-1:0]      w_grant_id_nxt;
    logic [ID_W-1:0]      w_ptr_nxt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic                 w_timeout_nxt;

    // Winner search helpers
    logic [2*NUM_REQ-1:0] w_req_dbl;
    logic [NUM_REQ-1:0]   w_req_rot;
    logic [ID_W-1:0]      w_off;
    logic [ID_W:0]        w_win_sum;
    logic [ID_W-1:0]      w_winner;
    logic                 w_any_req;
    logic [NUM_REQ-1:0]   w_winner_onehot;

    // Release helpers
    logic                 w_owner_done;
    logic                 w_owner_req;
    logic                 w_limit;
    logic                 w_release;
    logic [ID_W:0]        w_ptr_inc;
    logic [ID_W-1:0]      w_ptr_after;

    // Rotate the request vector so bit 0 is the slot the pointer names,
    // then take the lowest set bit and map it back to an absolute index.
    always_comb begin
        w_req_dbl = {req, req} >> r_ptr;
        w_req_rot = w_req_dbl[NUM_REQ-1:0];
        w_any_req = |req;
        w_off     = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (w_req_rot[i]) begin
                w_off = ID_W'(i);
            end
        end
        w_win_sum = {1'b0, r_ptr} + {1'b0, w_off};
        if (w_win_sum >= NREQ_EXT) begin
            w_win_sum = w_win_sum - NREQ_EXT;
        end
        w_winner        = w_win_sum[ID_W-1:0];
        w_winner_onehot = NUM_REQ'(1) << w_winner;
    end

    // Owner release conditions; only the owner's own req/done bits matter.
    always_comb begin
        w_owner_done = |(done & r_grant);
        w_owner_req  = |(req & r_grant);
        w_limit      = TIMEOUT_EN && (r_cnt == HOLD_LAST);
        w_release    = w_owner_done || !w_owner_req || w_limit;
        w_ptr_inc    = {1'b0, r_grant_id} + (ID_W + 1)'(1);
        if (w_ptr_inc == NREQ_EXT) begin
            w_ptr_after = '0;
        end else begin
            w_ptr_after = w_ptr_inc[ID_W-1:0];
        end
    end

    // Next-state and next-output logic for the IDLE/OWNED machine.
    always_comb begin
        w_state_nxt    = r_state;
        w_grant_nxt    = r_grant;
        w_grant_id_nxt = r_grant_id;
        w_ptr_nxt      = r_ptr;
        w_cnt_nxt      = r_cnt;
        w_timeout_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt    = ST_OWNED;
                    w_grant_nxt    = w_winner_onehot;
                    w_grant_id_nxt = w_winner;
                    w_cnt_nxt      = '0;
                end
            end
            ST_OWNED: begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
                if (w_release) begin
                    w_state_nxt   = ST_IDLE;
                    w_grant_nxt   = '0;
                    w_ptr_nxt     = w_ptr_after;
                    w_cnt_nxt     = '0;
                    // A forced revoke only counts when the owner did not
                    // release on its own in the same cycle.
                    w_timeout_nxt = w_limit && w_owner_req && !w_owner_done;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    // State and output registers; reset clears everything including the pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_grant    <= '0;
            r_grant_id <= '0;
            r_ptr      <= '0;
            r_cnt      <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_grant    <= w_grant_nxt;
            r_grant_id <= w_grant_id_nxt;
            r_ptr      <= w_ptr_nxt;
            r_cnt      <= w_cnt_nxt;
            r_timeout  <= w_timeout_nxt;
        end
    end

    assign grant       = r_grant;
    assign grant_valid = |r_grant;
    assign grant_id    = r_grant_id;
    assign timeout     = r_timeout;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Directed testbench for rr_grant_arbiter (NUM_REQ=4).
// Instance dut uses MAX_HOLD=8, instance dut0 uses MAX_HOLD=0.
module tb_rr_grant_arbiter;

    localparam int N = 4;
    localparam int W = 8;  // {grant[3:0], grant_valid, grant_id[1:0], timeout}

    // Clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [N-1:0] req, done, grant;
    logic         grant_valid, timeout, dbg_state;
    logic [1:0]   grant_id;

    logic [N-1:0] req0, done0, grant0;
    logic         grant_valid0, timeout0, dbg_state0;
    logic [1:0]   grant_id0;

    rr_grant_arbiter #(.NUM_REQ(N), .MAX_HOLD(8)) dut (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .grant(grant), .grant_valid(grant_valid), .grant_id(grant_id),
        .timeout(timeout), .dbg_state(dbg_state)
    );

    rr_grant_arbiter #(.NUM_REQ(N), .MAX_HOLD(0)) dut0 (
        .clk(clk), .rst(rst), .req(req0), .done(done0),
        .grant(grant0), .grant_valid(grant_valid0), .grant_id(grant_id0),
        .timeout(timeout0), .dbg_state(dbg_state0)
    );

    // Scoreboard
    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    typedef struct {
        logic [N-1:0] req;
        logic [N-1:0] done;
        logic [N-1:0] grant;
        logic         valid;
        logic [1:0]   id;
        logic         tmo;
    } vec_t;

    vec_t vecs[16];

    task automatic check_val(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got {grant,valid,id,tmo}=%b expected %b", name, act, exp);
        end
    endtask

    // Drive one cycle from a negedge, compare outputs at the next negedge.
    task automatic apply(input logic [N-1:0] r, input logic [N-1:0] d,
                         input logic [N-1:0] g, input logic v, input logic [1:0] id,
                         input logic t, input string name);
        logic [W-1:0] exp_v;
        req  = r;
        done = d;
        exp_q.push_back({g, v, id, t});
        @(negedge clk);
        exp_v = exp_q.pop_front();
        check_val(name, {grant, grant_valid, grant_id, timeout}, exp_v);
    endtask

    // Structural invariants on both instances.
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (!$onehot0(grant) || (grant_valid != |grant) || (timeout && grant_valid) ||
                !$onehot0(grant0) || (grant_valid0 != |grant0) || timeout0) begin
                errors++;
                $display("FAIL invariant: grant=%b valid=%b tmo=%b grant0=%b valid0=%b tmo0=%b",
                         grant, grant_valid, timeout, grant0, grant_valid0, timeout0);
            end
        end
    end

    initial begin
        rst = 1'b1; req = '0; done = '0; req0 = '0; done0 = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_val("reset_state", {grant, grant_valid, grant_id, timeout}, '0);

        // Idle with no requests.
        for (int i = 0; i < 5; i++) apply(4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, "idle");

        // All requesting, each owner releases on its 2nd owned cycle.
        vecs[0]  = '{4'b1111, 4'b0000, 4'b0001, 1'b1, 2'd0, 1'b0};
        vecs[1]  = '{4'b1111, 4'b0000, 4'b0001, 1'b1, 2'd0, 1'b0};
        vecs[2]  = '{4'b1111, 4'b0001, 4'b0000, 1'b0, 2'd0, 1'b0};
        vecs[3]  = '{4'b1111, 4'b0000, 4'b0010, 1'b1, 2'd1, 1'b0};
        vecs[4]  = '{4'b1111, 4'b0000, 4'b0010, 1'b1, 2'd1, 1'b0};
        vecs[5]  = '{4'b1111, 4'b0010, 4'b0000, 1'b0, 2'd1, 1'b0};
        vecs[6]  = '{4'b1111, 4'b0000, 4'b0100, 1'b1, 2'd2, 1'b0};
        vecs[7]  = '{4'b1111, 4'b0000, 4'b0100, 1'b1, 2'd2, 1'b0};
        vecs[8]  = '{4'b1111, 4'b0100, 4'b0000, 1'b0, 2'd2, 1'b0};
        vecs[9]  = '{4'b1111, 4'b0000, 4'b1000, 1'b1, 2'd3, 1'b0};
        vecs[10] = '{4'b1111, 4'b0000, 4'b1000, 1'b1, 2'd3, 1'b0};
        vecs[11] = '{4'b1111, 4'b1000, 4'b0000, 1'b0, 2'd3, 1'b0};
        vecs[12] = '{4'b1111, 4'b0000, 4'b0001, 1'b1, 2'd0, 1'b0};
        vecs[13] = '{4'b1111, 4'b0000, 4'b0001, 1'b1, 2'd0, 1'b0};
        vecs[14] = '{4'b1111, 4'b0001, 4'b0000, 1'b0, 2'd0, 1'b0};
        vecs[15] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0};
        for (int i = 0; i < 16; i++) begin
            apply(vecs[i].req, vecs[i].done, vecs[i].grant, vecs[i].valid,
                  vecs[i].id, vecs[i].tmo, $sformatf("rr_vec%0d", i));
        end

        // Hold limit: 8 owned cycles, timeout pulse with grant drop, regrant after gap.
        for (int i = 0; i < 8; i++) apply(4'b0100, 4'b0000, 4'b0100, 1'b1, 2'd2, 1'b0, "hold_owned");
        apply(4'b0100, 4'b0000, 4'b0000, 1'b0, 2'd2, 1'b1, "hold_timeout");
        apply(4'b0100, 4'b0000, 4'b0100, 1'b1, 2'd2, 1'b0, "hold_regrant");
        apply(4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd2, 1'b0, "hold_release");

        // MAX_HOLD=0: grant held indefinitely, never a timeout.
        req0 = 4'b0100;
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            check_val("nohold_owned", {grant0, grant_valid0, grant_id0, timeout0}, {4'b0100, 1'b1, 2'd2, 1'b0});
            @(negedge clk);
        end
        req0 = 4'b0000;
        @(negedge clk);
        check_val("nohold_release", {grant0, grant_valid0, grant_id0, timeout0}, {4'b0000, 1'b0, 2'd2, 1'b0});

        // Owner 1 drops req; done[3] during ownership is ignored. ptr=3 here.
        apply(4'b0010, 4'b0000, 4'b0010, 1'b1, 2'd1, 1'b0, "own1_grant");
        apply(4'b1010, 4'b1000, 4'b0010, 1'b1, 2'd1, 1'b0, "own1_ignore_done3");
        apply(4'b1000, 4'b1000, 4'b0000, 1'b0, 2'd1, 1'b0, "own1_req_drop");
        apply(4'b1000, 4'b0000, 4'b1000, 1'b1, 2'd3, 1'b0, "own3_grant");
        apply(4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd3, 1'b0, "own3_release");

        // done coincides with the hold limit: plain release, no timeout. ptr=0 here.
        apply(4'b0100, 4'b0000, 4'b0100, 1'b1, 2'd2, 1'b0, "lim_grant");
        for (int i = 0; i < 7; i++) apply(4'b0100, 4'b0000, 4'b0100, 1'b1, 2'd2, 1'b0, "lim_owned");
        apply(4'b0101, 4'b0100, 4'b0000, 1'b0, 2'd2, 1'b0, "lim_done_no_tmo");
        apply(4'b0101, 4'b0000, 4'b0001, 1'b1, 2'd0, 1'b0, "lim_next_ptr3");
        apply(4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, "lim_release");

        // Reset mid-grant with ptr=2, then ptr must restart at 0. ptr=1 here.
        apply(4'b0010, 4'b0000, 4'b0010, 1'b1, 2'd1, 1'b0, "rst_pre_grant");
        apply(4'b0010, 4'b0010, 4'b0000, 1'b0, 2'd1, 1'b0, "rst_pre_release");
        apply(4'b0010, 4'b0000, 4'b0010, 1'b1, 2'd1, 1'b0, "rst_pre_grant_ptr2");
        rst = 1'b1;
        #1;
        check_val("async_reset", {grant, grant_valid, grant_id, timeout}, '0);
        #1;
        rst = 1'b0;
        apply(4'b1010, 4'b0000, 4'b0010, 1'b1, 2'd1, 1'b0, "post_reset_ptr0");
        apply(4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd1, 1'b0, "post_reset_release");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
